proc_mem_responder: RTL

- Responder end of the processor-request interface: accepts processor_request_t (cs, rw, flush, addr, data) and answers with processor_response_t (hold_cpu) plus proc_res_data.
- Flat, uncached word memory with programmable wait states and a timed flush acknowledge.
- Drop-in replacement for the cache in processor/cache test tops; serves as the golden timing model and as a protocol checker for request generators.

---
 rtl/cache_structs_def.sv | 30 +++
 rtl/proc_mem_responder_ram.sv | 33 +++
 rtl/proc_mem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_structs_def.sv
// Shared types for the processor-request interface and the flat-memory
// responder.
//   processor_request_t  : cs, rw (1 = store), flush, addr[29:0], data[31:0]
//   processor_response_t : hold_cpu
//   resp_state_t         : responder FSM states
//   RESP_CNT_W           : width of the responder wait-state counter
package cache_structs_def;

  localparam int DATA_WIDTH = 32;
  localparam int RESP_CNT_W = 8;

  typedef struct packed {
    logic        cs;
    logic        rw;
    logic        flush;
    logic [29:0] addr;
    logic [31:0] data;
  } processor_request_t;

  typedef struct packed {
    logic hold_cpu;
  } processor_response_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/proc_mem_responder_ram.sv
// Single-port synchronous RAM with write enable and registered read.
// Written in the plain inferable form so vendor tools map it to block RAM.
//   clk   : clock
//   we    : write enable, writes wdata at addr on the rising edge
//   re    : read enable, registers mem[addr] into rdata on the rising edge
//   addr  : shared read/write word index
//   wdata : write data
//   rdata : registered read data (holds between reads)
module proc_mem_responder_ram
  import cache_structs_def::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q   <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/proc_mem_responder.sv
// Flat uncached word memory answering the processor-request interface with
// programmable wait states and a timed flush acknowledge. Also watches the
// initiator for protocol violations.
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   proc_req      : request (cs, rw, flush, addr, data)
//   proc_res      : response, only hold_cpu is driven
//   proc_res_data : load data, valid in RESP of a load and held afterwards
//   rd_cnt/wr_cnt/fl_cnt : saturating completed-operation counters
//   addr_err      : sticky, a captured address had bits above ADDR_BITS set
//   proto_err     : sticky, request dropped or changed while held
module proc_mem_responder
  import cache_structs_def::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_BITS    = 10,
  parameter int LATENCY      = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  processor_request_t    proc_req,
  output processor_response_t   proc_res,
  output logic [DATA_WIDTH-1:0] proc_res_data,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           fl_cnt,
  output logic                  addr_err,
  output logic                  proto_err
);

  localparam logic [RESP_CNT_W-1:0] LAT_LOAD = RESP_CNT_W'(LATENCY - 1);
  localparam logic [RESP_CNT_W-1:0] FL_LOAD  = RESP_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [31:0]           CNT_MAX  = '1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  resp_state_t           state_q, state_d;
  logic [RESP_CNT_W-1:0] wcnt_q, wcnt_d, load_val;
  logic [29:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  flush_q, flush_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic [31:0]           fl_cnt_q, fl_cnt_d;
  logic                  addr_err_q, addr_err_d;
  logic                  proto_err_q, proto_err_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;

  logic                  is_load_q, is_store_q, load_next;
  logic                  upper_nz, req_changed;
  logic                  ram_we, ram_re;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flush outranks rw, so a flush never touches memory.
  assign is_load_q  = !flush_q && !rw_q;
  assign is_store_q = !flush_q &&  rw_q;
  assign load_val   = proc_req.flush ? FL_LOAD : LAT_LOAD;
  assign upper_nz   = (proc_req.addr >> ADDR_BITS) != 30'd0;
  assign req_changed = (proc_req.addr  != addr_q)
                    || (DATA_WIDTH'(proc_req.data) != wdata_q)
                    || (proc_req.rw    != rw_q)
                    || (proc_req.flush != flush_q);

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ---------------------------------------------------------- FSM next state
  // WAIT lasts load_val cycles; together with the IDLE capture cycle that
  // gives exactly LATENCY (or FLUSH_CYCLES) held cycles.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (proc_req.cs) begin
          wcnt_d  = load_val;
          state_d = (load_val == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - RESP_CNT_W'(1);
        if (wcnt_q == RESP_CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------- FSM outputs
  // hold_cpu is combinational from cs in IDLE so the initiator is stalled in
  // its very first request cycle; reset masks it.
  always_comb begin
    proc_res          = '0;
    proc_res.hold_cpu = rst && (((state_q == IDLE) && proc_req.cs) || (state_q == WAIT));
    proc_res_data     = ((state_q == RESP) && is_load_q) ? ram_rdata : rdata_hold_q;
  end

  // --------------------------------------------------------- RAM interface
  // The read is issued on the edge entering RESP. In IDLE the request has not
  // been captured yet, so the live address is used (LATENCY = 1 case).
  // Stores commit on the edge leaving RESP, always before any later read.
  assign load_next = (state_q == IDLE) ? (!proc_req.flush && !proc_req.rw) : is_load_q;
  assign ram_re    = (state_d == RESP) && load_next;
  assign ram_we    = (state_q == RESP) && is_store_q;
  assign ram_addr  = (state_q == IDLE) ? proc_req.addr[ADDR_BITS-1:0]
                                       : addr_q[ADDR_BITS-1:0];

  proc_mem_responder_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // ------------------------------------------- capture, counters, checkers
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    flush_d      = flush_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    fl_cnt_d     = fl_cnt_q;
    addr_err_d   = addr_err_q;
    proto_err_d  = proto_err_q;
    rdata_hold_d = rdata_hold_q;

    if ((state_q == IDLE) && proc_req.cs) begin
      addr_d  = proc_req.addr;
      wdata_d = DATA_WIDTH'(proc_req.data);
      rw_d    = proc_req.rw;
      flush_d = proc_req.flush;
      if (upper_nz) addr_err_d = 1'b1;
    end

    // Only WAIT is checked; the initiator may drop or change cs in RESP.
    if ((state_q == WAIT) && (!proc_req.cs || req_changed)) proto_err_d = 1'b1;

    if (state_q == RESP) begin
      if (flush_q) begin
        fl_cnt_d = sat_inc(fl_cnt_q);
      end else if (rw_q) begin
        wr_cnt_d = sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_d     = sat_inc(rd_cnt_q);
        rdata_hold_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      flush_q      <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      fl_cnt_q     <= '0;
      addr_err_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      flush_q      <= flush_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      fl_cnt_q     <= fl_cnt_d;
      addr_err_q   <= addr_err_d;
      proto_err_q  <= proto_err_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign fl_cnt    = fl_cnt_q;
  assign addr_err  = addr_err_q;
  assign proto_err = proto_err_q;

endmodule
